mix_columns_seq: RTL and testbench

- Column-serial AES MixColumns stage that consumes the per-byte GF(2^8) multiply primitives (xtimes, MUL3).
- Sits between ShiftRows and AddRoundKey in the AES-256 round datapath.
- Accepts a 128-bit state over a valid/ready handshake and processes one 32-bit column per clock.
- Presents the mixed 128-bit state over a valid/ready handshake.

---
 rtl/aes_mc_pkg.sv | 18 +
 rtl/mix_columns_seq_if.sv | 24 ++
 rtl/mix_single_column.sv | 52 +++++
 rtl/mul3.sv | 7 +
 rtl/xtimes.sv | 7 +
 rtl/mix_columns_seq.sv | 79 +++++++
 tb/tb_mix_columns_seq.sv | 221 ++++++++++++++++++++++
 7 files changed

// File: rtl/aes_mc_pkg.sv
// rtl/aes_mc_pkg.sv - shared sizes, FSM encoding and column slicing for mix_columns_seq
package aes_mc_pkg;
  localparam int NUM_COLS = 4;
  localparam int COL_W    = 32;
  localparam int STATE_W  = 128;
  localparam int CNT_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // MSB index of column c; column 0 occupies the top 32 bits of the state
  function automatic int col_hi(input int c);
    return STATE_W - 1 - COL_W * c;
  endfunction
endpackage

// File: rtl/mix_columns_seq_if.sv
// rtl/mix_columns_seq_if.sv - input/output handshakes of mix_columns_seq (inv_mode with INV_MIX_COLUMNS_EN)
interface mix_columns_seq_if;
  import aes_mc_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
`ifdef INV_MIX_COLUMNS_EN
  logic               inv_mode;

  modport master (output in_valid, in_state, out_ready, inv_mode,
                  input  in_ready, out_valid, out_state);
  modport slave  (input  in_valid, in_state, out_ready, inv_mode,
                  output in_ready, out_valid, out_state);
`else
  modport master (output in_valid, in_state, out_ready,
                  input  in_ready, out_valid, out_state);
  modport slave  (input  in_valid, in_state, out_ready,
                  output in_ready, out_valid, out_state);
`endif
endinterface

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational MixColumns of one column; inverse coefficients with INV_MIX_COLUMNS_EN
module mix_single_column (
  input  logic [31:0] col,
`ifdef INV_MIX_COLUMNS_EN
  input  logic        inv,
`endif
  output logic [31:0] mixed
);
  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x3 [4];
  logic [31:0] fwd;

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i] = col[31-8*i -: 8];
    xtimes u_x2 (.a(a[i]), .y(x2[i]));
    mul3   u_x3 (.a(a[i]), .y(x3[i]));
  end

  assign fwd = {x2[0] ^ x3[1] ^ a[2]  ^ a[3],
                a[0]  ^ x2[1] ^ x3[2] ^ a[3],
                a[0]  ^ a[1]  ^ x2[2] ^ x3[3],
                x3[0] ^ a[1]  ^ a[2]  ^ x2[3]};

`ifdef INV_MIX_COLUMNS_EN
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [31:0] inv_col;

  // 9, b, d, e assembled from the 2/4/8 xtimes chain
  for (genvar i = 0; i < 4; i++) begin : g_inv
    xtimes u_x4 (.a(x2[i]), .y(x4[i]));
    xtimes u_x8 (.a(x4[i]), .y(x8[i]));
    assign m9[i] = x8[i] ^ a[i];
    assign mb[i] = x8[i] ^ x2[i] ^ a[i];
    assign md[i] = x8[i] ^ x4[i] ^ a[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  assign inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  assign mixed = inv ? inv_col : fwd;
`else
  assign mixed = fwd;
`endif
endmodule

// File: rtl/mul3.sv
// rtl/mul3.sv - GF(2^8) multiply by 3 (xtimes(a) ^ a)
module mul3 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00) ^ a;
endmodule

// File: rtl/xtimes.sv
// rtl/xtimes.sv - GF(2^8) multiply by 2 with reduction polynomial 0x11B
module xtimes (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - column-serial AES MixColumns, one column per cycle; INV_MIX_COLUMNS_EN adds inv_mode
module mix_columns_seq
  import aes_mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mix_columns_seq_if.slave  bus
);
  mc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [STATE_W-1:0] work_q;
  logic [COL_W-1:0]   col_in, col_out;
  logic               last_col;
  logic               in_ready_c, out_valid_c;

  assign last_col = (cnt_q == CNT_W'(NUM_COLS - 1));
  assign col_in   = work_q[col_hi(int'(cnt_q)) -: COL_W];

`ifdef INV_MIX_COLUMNS_EN
  logic inv_q;

  mix_single_column u_mix (.col(col_in), .inv(inv_q), .mixed(col_out));
`else
  mix_single_column u_mix (.col(col_in), .mixed(col_out));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: if (last_col) state_d = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // each BUSY cycle overwrites the column just mixed in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      work_q <= '0;
`ifdef INV_MIX_COLUMNS_EN
      inv_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          work_q <= bus.in_state;
          cnt_q  <= '0;
`ifdef INV_MIX_COLUMNS_EN
          inv_q  <= bus.inv_mode;
`endif
        end
        BUSY: begin
          work_q[col_hi(int'(cnt_q)) -: COL_W] <= col_out;
          cnt_q <= last_col ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_state = work_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - self-checking bench for mix_columns_seq (exercises inv_mode with INV_MIX_COLUMNS_EN)
module tb_mix_columns_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mix_columns_seq_if bus ();
  mix_columns_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] R2  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V80 = 128'h80808080_80808080_80808080_80808080;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // state mixed by the circulant MixColumns matrix (or its inverse)
  function automatic logic [127:0] model_mix(input logic [127:0] s, input bit inv);
    logic [7:0] fwd [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] ivc [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] res = '0;
    logic [7:0] acc;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(s[127-32*c-8*j -: 8], inv ? ivc[(j - row + 4) % 4] : fwd[(j - row + 4) % 4]);
        res[127-32*c-8*row -: 8] = acc;
      end
    return res;
  endfunction

  logic inv_sig;
`ifdef INV_MIX_COLUMNS_EN
  assign inv_sig = bus.inv_mode;
`else
  assign inv_sig = 1'b0;
`endif

  bit           pending = 0;
  int           age = 0;
  logic [127:0] exp_q = '0;
  int           n_acc = 0;
  int           n_res = 0;
  logic [127:0] res_q [$];

  // protocol model: accept when idle, result 4 edges later, held until out_ready
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      age = 0;
    end else begin
      check("in_ready", 128'(bus.in_ready), 128'(!pending));
      check("out_valid", 128'(bus.out_valid), 128'(pending && age == 4));
      if (pending && age == 4) check("out_state", bus.out_state, exp_q);
      if (!pending) begin
        if (bus.in_valid) begin
          pending = 1;
          age = 0;
          exp_q = model_mix(bus.in_state, inv_sig);
          n_acc++;
        end
      end else if (age < 4) begin
        age++;
      end else if (bus.out_ready) begin
        pending = 0;
        res_q.push_back(bus.out_state);
        n_res++;
      end
    end
  end

  task automatic set_inv(input bit inv);
`ifdef INV_MIX_COLUMNS_EN
    bus.inv_mode = inv;
`else
    if (inv) $display("inv_mode unavailable in this build");
`endif
  endtask

  task automatic run_vec(input logic [127:0] s, input bit inv, input int hold,
                         output logic [127:0] res, output int lat);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_state = s;
    set_inv(inv);
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_in_time", 128'(n < 50), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = bus.out_state;
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("stall_in_ready", 128'(bus.in_ready), 128'(0));
        check("stall_out_valid", 128'(bus.out_valid), 128'(1));
        check("stall_out_state", bus.out_state, res);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("in_ready_after_hs", 128'(bus.in_ready), 128'(1));
    check("out_valid_after_hs", 128'(bus.out_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    int lat;
    int n;
    int a0, r0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_state = '0;
    bus.out_ready = 1'b1;
    set_inv(1'b0);
    #3;
    check("reset_in_ready", 128'(bus.in_ready), 128'(1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check("reset_out_state", bus.out_state, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    check("model_fwd_v1", model_mix(V1, 1'b0), R1);
    check("model_fwd_v2", model_mix(V2, 1'b0), R2);
    check("model_inv_r1", model_mix(R1, 1'b1), V1);

    run_vec(V1, 1'b0, 0, res, lat);
    check("fips_result", res, R1);
    check("fips_latency", 128'(lat), 128'(4));

    run_vec(V2, 1'b0, 10, res, lat);
    check("stall_result", res, R2);
    check("stall_cols01", {64'h0, res[127:64]}, 128'hd5d5d7d6_4d7ebdf8);

    // back-to-back: in_valid stays high across two states
    a0 = n_acc;
    r0 = n_res;
    res_q.delete();
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_state = V2;
    n = 0;
    while (n_acc < a0 + 1 && n < 50) begin @(posedge clk); #1; n++; end
    bus.in_state = V80;
    while (n_acc < a0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b0;
    while (n_res < r0 + 2 && n < 150) begin @(posedge clk); #1; n++; end
    check("b2b_count", 128'(res_q.size()), 128'(2));
    if (res_q.size() == 2) begin
      check("b2b_first", res_q[0], R2);
      check("b2b_second", res_q[1], V80);
    end

    // reset during BUSY
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_state = V1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    check("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    check("midrst_out_state", bus.out_state, 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(V1, 1'b0, 0, res, lat);
    check("post_reset_result", res, R1);

`ifdef INV_MIX_COLUMNS_EN
    run_vec(R1, 1'b1, 0, res, lat);
    check("inv_round_trip", res, V1);
    check("inv_latency", 128'(lat), 128'(4));
    run_vec(V1, 1'b0, 0, res, lat);
    check("fwd_after_inv", res, R1);
`endif

    run_vec(128'h0, 1'b0, 0, res, lat);
    check("all_zero", res, 128'h0);
    run_vec(V80, 1'b0, 0, res, lat);
    check("xtimes_reduce_80", res, V80);

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
